// File: rtl/alu_req_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_req_arb_pkg
// Brief  : Shared sizing helpers for the ALU request arbiter and its pick logic.
// Rev    : 1.0  initial release
// ============================================================================
package alu_req_arb_pkg;

  // Index width that never collapses to zero bits, even for a single entry.
  function automatic int calc_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_req_arb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin pick: first eligible index at or after rr_ptr.
// Rev    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQS = 4,
  parameter int REQ_BITS = 2
) (
  input  logic [NUM_REQS-1:0] elig,
  input  logic [REQ_BITS-1:0] rr_ptr,
  output logic [REQ_BITS-1:0] winner,
  output logic                any
);

  logic [2*NUM_REQS-1:0] w_dbl;
  logic [2*NUM_REQS-1:0] w_shift;
  logic [NUM_REQS-1:0]   w_rot;
  int                    w_off;
  int                    w_sum;

  // Rotating a doubled copy puts rr_ptr at bit 0, so wrap-around becomes a plain priority scan.
  assign w_dbl   = {elig, elig};
  assign w_shift = w_dbl >> rr_ptr;
  assign w_rot   = w_shift[NUM_REQS-1:0];
  assign any     = |elig;

  always_comb begin
    w_off = 0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = i;
    end
    w_sum = int'(rr_ptr) + w_off;
    if (w_sum >= NUM_REQS) w_sum = w_sum - NUM_REQS;
    winner = REQ_BITS'(w_sum);
  end

endmodule
`default_nettype wire

// File: rtl/alu_req_arb.sv
`default_nettype none
// ============================================================================
// Module : alu_req_arb
// Brief  : Round-robin share of one ALU execute port with per-warp branch serialization.
// Rev    : 1.0  initial release
// ============================================================================
module alu_req_arb
  import alu_req_arb_pkg::*;
#(
  parameter int NUM_REQS  = 4,
  parameter int NUM_WARPS = 4,
  parameter int DATAW     = 64,
  localparam int REQ_BITS = calc_bits(NUM_REQS),
  localparam int NW_BITS  = calc_bits(NUM_WARPS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQS-1:0]                req_valid,
  input  logic [NUM_REQS-1:0][DATAW-1:0]     req_data,
  input  logic [NUM_REQS-1:0][NW_BITS-1:0]   req_wid,
  input  logic [NUM_REQS-1:0]                req_is_br,
  output logic [NUM_REQS-1:0]                req_ready,
  output logic                               out_valid,
  output logic [DATAW-1:0]                   out_data,
  output logic [NW_BITS-1:0]                 out_wid,
  output logic [REQ_BITS-1:0]                out_sel,
  input  logic                               out_ready,
  input  logic                               br_valid,
  input  logic [NW_BITS-1:0]                 br_wid,
  output logic [NUM_WARPS-1:0]               br_pending
);

  typedef struct packed {
    logic [DATAW-1:0]   data;
    logic [NW_BITS-1:0] wid;
    logic               is_br;
  } alu_arb_req_t;

  logic                 r_out_valid;
  logic [DATAW-1:0]     r_out_data;
  logic [NW_BITS-1:0]   r_out_wid;
  logic [REQ_BITS-1:0]  r_out_sel;
  logic [REQ_BITS-1:0]  r_rr_ptr;
  logic [NUM_WARPS-1:0] r_br_pending;

  logic [NUM_REQS-1:0]  w_elig;
  logic [REQ_BITS-1:0]  w_winner;
  logic                 w_any;
  logic                 w_load;
  logic                 w_fire;
  alu_arb_req_t         w_sel_req;
  logic [REQ_BITS-1:0]  w_ptr_next;
  logic [NUM_WARPS-1:0] w_pend_next;
  logic                 w_br_collide;

  // Eligibility looks only at the registered pending mask; a same-cycle br_valid is not bypassed.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      w_elig[i] = req_valid[i];
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (req_wid[i] == NW_BITS'(w) && r_br_pending[w]) w_elig[i] = 1'b0;
      end
    end
  end

  rr_arbiter #(
    .NUM_REQS (NUM_REQS),
    .REQ_BITS (REQ_BITS)
  ) u_rr_arbiter (
    .elig   (w_elig),
    .rr_ptr (r_rr_ptr),
    .winner (w_winner),
    .any    (w_any)
  );

  assign w_load = ~r_out_valid | out_ready;
  assign w_fire = w_load & w_any & ~reset;

  always_comb begin
    req_ready = '0;
    if (w_fire) req_ready[w_winner] = 1'b1;
  end

  assign w_sel_req.data  = req_data[w_winner];
  assign w_sel_req.wid   = req_wid[w_winner];
  assign w_sel_req.is_br = req_is_br[w_winner];

  assign w_ptr_next = (w_winner == REQ_BITS'(NUM_REQS - 1)) ? '0 : w_winner + 1'b1;

  // Clear first, then set, so a set on the same warp wins.
  always_comb begin
    w_pend_next = r_br_pending;
    if (br_valid) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (br_wid == NW_BITS'(w)) w_pend_next[w] = 1'b0;
      end
    end
    if (w_fire && w_sel_req.is_br) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (w_sel_req.wid == NW_BITS'(w)) w_pend_next[w] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_wid    <= '0;
      r_out_sel    <= '0;
      r_rr_ptr     <= '0;
      r_br_pending <= '0;
    end else begin
      if (w_fire) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_req.data;
        r_out_wid   <= w_sel_req.wid;
        r_out_sel   <= w_winner;
        r_rr_ptr    <= w_ptr_next;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      r_br_pending <= w_pend_next;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_wid    = r_out_wid;
  assign out_sel    = r_out_sel;
  assign br_pending = r_br_pending;

  // A branch cannot resolve in the same cycle its own warp issues another branch.
  assign w_br_collide = w_fire & w_sel_req.is_br & br_valid & (br_wid == w_sel_req.wid);

  a_no_br_collide : assert property (@(posedge clk) disable iff (reset) !w_br_collide);

endmodule
`default_nettype wire

// File: tb/tb_alu_req_arb.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_req_arb
// Brief  : Directed self-checking bench for alu_req_arb (4 requesters, 4 warps).
// Rev    : 1.0  initial release
// ============================================================================
module tb_alu_req_arb;

  logic             clk;
  logic             reset;
  logic [3:0]       req_valid;
  logic [3:0][63:0] req_data;
  logic [3:0][1:0]  req_wid;
  logic [3:0]       req_is_br;
  logic [3:0]       req_ready;
  logic             out_valid;
  logic [63:0]      out_data;
  logic [1:0]       out_wid;
  logic [1:0]       out_sel;
  logic             out_ready;
  logic             br_valid;
  logic [1:0]       br_wid;
  logic [3:0]       br_pending;

  int n_checks = 0;
  int n_fail   = 0;

  alu_req_arb #(
    .NUM_REQS  (4),
    .NUM_WARPS (4),
    .DATAW     (64)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_wid    (req_wid),
    .req_is_br  (req_is_br),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_wid    (out_wid),
    .out_sel    (out_sel),
    .out_ready  (out_ready),
    .br_valid   (br_valid),
    .br_wid     (br_wid),
    .br_pending (br_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] dval(input int i);
    return 64'hD0 + 64'(i);
  endfunction

  initial begin
    reset     = 1'b1;
    req_valid = 4'hF;
    req_is_br = 4'h0;
    req_wid   = '0;
    out_ready = 1'b1;
    br_valid  = 1'b0;
    br_wid    = 2'd0;
    for (int i = 0; i < 4; i++) req_data[i] = dval(i);

    // Reset state, with requests presented to confirm req_ready is held low.
    #1;
    check_val("rst_ready", 64'(req_ready), 64'h0);
    check_val("rst_out_valid", 64'(out_valid), 64'h0);
    check_val("rst_br_pending", 64'(br_pending), 64'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Fairness: 0,1,2,3,0,1 with out_sel trailing by one cycle.
    for (int k = 0; k < 6; k++) begin
      #1;
      check_val("fair_ready", 64'(req_ready), 64'(1 << (k % 4)));
      if (k > 0) begin
        check_val("fair_sel", 64'(out_sel), 64'((k - 1) % 4));
        check_val("fair_data", out_data, dval((k - 1) % 4));
      end
      @(negedge clk);
    end

    // Wrap with holes from rr_ptr=2: grants 3, 1, 3.
    req_valid = 4'b1010;
    #1;
    check_val("fair_last_sel", 64'(out_sel), 64'd1);
    check_val("holes_ready0", 64'(req_ready), 64'b1000);
    @(negedge clk);
    #1;
    check_val("holes_sel0", 64'(out_sel), 64'd3);
    check_val("holes_ready1", 64'(req_ready), 64'b0010);
    @(negedge clk);
    #1;
    check_val("holes_sel1", 64'(out_sel), 64'd1);
    check_val("holes_ready2", 64'(req_ready), 64'b1000);
    @(negedge clk);

    // Backpressure: output held for 3 cycles even though the source payload changes.
    req_valid   = 4'b1000;
    out_ready   = 1'b0;
    req_data[3] = 64'h33BB;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_val("bp_ready", 64'(req_ready), 64'h0);
      check_val("bp_valid", 64'(out_valid), 64'h1);
      check_val("bp_data", out_data, dval(3));
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check_val("bp_resume", 64'(req_ready), 64'b1000);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    check_val("bp_new_data", out_data, 64'h33BB);
    @(negedge clk);
    #1;
    check_val("drain_valid", 64'(out_valid), 64'h0);

    // Branch serialization on warp 2; rr_ptr is 0 here.
    req_wid[0] = 2'd2;
    req_wid[1] = 2'd2;
    req_wid[2] = 2'd1;
    req_is_br  = 4'b0001;
    req_valid  = 4'b0011;
    #1;
    check_val("br_t_ready", 64'(req_ready), 64'b0001);
    @(negedge clk);
    req_valid = 4'b0110;
    #1;
    check_val("br_t1_pending", 64'(br_pending), 64'b0100);
    check_val("br_t1_ready", 64'(req_ready), 64'b0100);
    check_val("br_t1_sel", 64'(out_sel), 64'd0);
    @(negedge clk);
    req_valid = 4'b0010;
    br_valid  = 1'b1;
    br_wid    = 2'd3;
    #1;
    check_val("br_t2_ready", 64'(req_ready), 64'h0);
    @(negedge clk);
    br_valid = 1'b0;
    #1;
    check_val("spur_pending", 64'(br_pending), 64'b0100);
    check_val("br_t3_ready", 64'(req_ready), 64'h0);
    @(negedge clk);
    #1;
    check_val("br_t4_ready", 64'(req_ready), 64'h0);
    @(negedge clk);
    br_valid = 1'b1;
    br_wid   = 2'd2;
    #1;
    check_val("br_t5_ready", 64'(req_ready), 64'h0);
    @(negedge clk);
    br_valid = 1'b0;
    #1;
    check_val("br_t6_pending", 64'(br_pending), 64'h0);
    check_val("br_t6_ready", 64'(req_ready), 64'b0010);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    check_val("br_t7_sel", 64'(out_sel), 64'd1);
    check_val("br_t7_wid", 64'(out_wid), 64'd2);
    @(negedge clk);

    // Asynchronous reset with a held output and warp 1 pending.
    req_wid[0] = 2'd1;
    req_valid  = 4'b0001;
    #1;
    check_val("mid_ready", 64'(req_ready), 64'b0001);
    @(negedge clk);
    req_valid = 4'b0000;
    req_is_br = 4'b0000;
    #1;
    check_val("mid_valid", 64'(out_valid), 64'h1);
    check_val("mid_pending", 64'(br_pending), 64'b0010);
    #1;
    reset     = 1'b1;
    req_valid = 4'hF;
    #1;
    check_val("arst_valid", 64'(out_valid), 64'h0);
    check_val("arst_data", out_data, 64'h0);
    check_val("arst_pending", 64'(br_pending), 64'h0);
    check_val("arst_ready", 64'(req_ready), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("post_rst_ptr", 64'(req_ready), 64'b0001);
    @(negedge clk);
    #1;
    check_val("post_rst_sel", 64'(out_sel), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_req_arb.md
# alu_req_arb

Round-robin arbiter that shares one ALU execute port (ALU + optional muldiv) among `NUM_REQS` issue-side request streams. It sits between the per-slot issue queues and the ALU unit's request interface. Its output register isolates the arbiter from the ALU's `ready`. Branches are serialized per warp: once a branch op is granted for warp `w`, no further request from `w` is granted until the ALU's branch-control output reports the resolution for `w`.

## Interface
- `NUM_REQS`, default 4: number of requesters, ≥1.
- `NUM_WARPS`, default 4: warps tracked for branch serialization.
- `DATAW`, default 64: opaque request payload width (uuid/PC/rd/op/operands, packed upstream).
- `REQ_BITS` (local) = max(1, clog2(`NUM_REQS`)). `NW_BITS` (local) = max(1, clog2(`NUM_WARPS`)).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  `NUM_REQS`  per-requester valid.
- `req_data`  in  `NUM_REQS`×`DATAW`  payload.
- `req_wid`  in  `NUM_REQS`×`NW_BITS`  warp id.
- `req_is_br`  in  `NUM_REQS`  request is a branch/jump/ecall/ebreak.
- `req_ready`  out  `NUM_REQS`  one-hot grant, gated by output-register availability.
- `out_valid`  out  1  ALU request valid.
- `out_data`  out  `DATAW`  granted payload.
- `out_wid`  out  `NW_BITS`  granted warp id.
- `out_sel`  out  `REQ_BITS`  index of the granted requester.
- `out_ready`  in  1  ALU accepts.
- `br_valid`  in  1  branch resolved (ALU `branch_ctl` valid).
- `br_wid`  in  `NW_BITS`  warp of the resolved branch.
- `br_pending`  out  `NUM_WARPS`  per-warp outstanding-branch mask (debug/scheduler visibility).

## Operation
- **Eligibility:** `elig[i] = req_valid[i] & ~br_pending_r[req_wid[i]]`. The registered mask is used; there is no bypass from `br_valid`.
- **Arbitration:** the first eligible index at or after `rr_ptr`, scanning with wrap-around modulo `NUM_REQS`.
- **Load enable:** `load = ~out_valid | out_ready`. `req_ready[i] = load & (i == winner) & (|elig)`. At most one bit is set.
- **Handshake:** on `req_valid[i] & req_ready[i]`:
  - the output register loads data, wid, and sel, and sets `out_valid` to 1;
  - `rr_ptr` becomes winner+1, wrapping to 0 after `NUM_REQS`-1;
  - if `req_is_br[i]`, `br_pending_r[req_wid[i]]` is set.
- **Drain without refill:** `out_valid & out_ready` with no new grant clears `out_valid`.
- **Branch clear:** `br_valid` clears `br_pending_r[br_wid]`. `br_valid` for a non-pending warp is ignored. If set and clear hit the same warp in the same cycle, set wins. This cannot occur legally; it is flagged by an assertion.
- `rr_ptr` is unchanged when no grant occurs.
- A branch from warp `w` does not block other warps.

## Timing
- **Reset values:** `out_valid`=0, `out_data`=0, `out_wid`=0, `out_sel`=0, `br_pending`=0, `rr_ptr`=0. `req_ready`=0 while reset is asserted.
- **Latency:** a request is presented on `out_*` one cycle after its handshake. Full throughput is one grant per cycle while `out_ready`=1.
- `req_ready` is combinational from `req_valid`, `req_wid`, `out_valid`, `out_ready`, and the registered state. Requesters must not make `req_valid` depend on `req_ready`.
- **Output stability:** `out_*` is held stable while `out_valid & ~out_ready`.
- **Branch stall window:** a same-warp request is blocked from the cycle after the branch handshake through the cycle of `br_valid`. It can be granted in the cycle after `br_valid`.
- **Reset mid-operation:** asynchronous assertion drops any held output and all pending flags immediately. Upstream must re-issue.

## Structure
- Shared package (`VX_gpu_pkg` or equivalent) holds `REQ_BITS`/`NW_BITS` helpers and an `alu_arb_req_t` struct packing {`data`, `wid`, `is_br`}, so the packed payload width is defined once.
- One natural sub-module: `rr_arbiter`, a pure combinational round-robin priority pick taking `elig` and `rr_ptr` and producing `winner` and `any`. It is reusable for the commit-side arbiter.
- Output register and pending mask live in the top. The top uses an always_ff with asynchronous reset on `reset`.

## Test plan
- **Reset:** assert `reset` mid-stream with `out_valid`=1 and `br_pending`=4'b0010. Outputs go to 0 without a clock edge, and `rr_ptr`=0 on release.
- **Fairness:** all 4 requesters valid, non-branch, `out_ready`=1. Grant order is 0,1,2,3,0,… with one grant per cycle and `out_sel` lagging by one cycle.
- **Backpressure:** `out_ready`=0 for 3 cycles with `out_valid`=1. `req_ready`=0 and `out_data` is stable for those cycles; grant resumes in the cycle `out_ready`=1.
- **Branch serialization:** req0 is a branch with wid=2 and is granted at cycle t; req1 has wid=2 and is valid continuously.
  - req1 is not granted until `br_valid`=1 with `br_wid`=2 at cycle t+5.
  - req1 is granted at t+6.
  - A wid=1 request is granted at t+1.
- **Spurious clear:** `br_valid`/`br_wid`=3 with no pending for warp 3. No state change and no effect on grants.
- **Wrap with holes:** only req3 and req1 valid, `rr_ptr`=2. Grants are 3, then 1, then 3.
